// File: rtl/leddot_scan.sv
// 8x8 LED dot-matrix row scanner with double-buffered frame memory.
// The CPU fills the back buffer one row at a time. A commit write asks for
// the whole back buffer to be copied to the front buffer at the next frame
// boundary, so a partly written image is never shown.
module leddot_scan #(
    parameter logic [15:0] SCAN_DIV  = 16'd50000,
    parameter logic [15:0] SCAN_ADDR = 16'hf004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] conf_addr,
    input  logic        conf_wen,
    input  logic [31:0] cpu_data_wdata,
    output logic [7:0]  led_dotr,
    output logic [7:0]  led_dotc,
    output logic        frame_done
);

    localparam int unsigned ROWS    = 8;
    localparam int unsigned COLS    = 8;
    localparam int unsigned ROW_W   = 3;
    localparam int unsigned DIV_W   = 16;

    logic [DIV_W-1:0] div_cnt;
    logic [ROW_W-1:0] row;
    logic [COLS-1:0]  back  [ROWS];
    logic [COLS-1:0]  front [ROWS];
    logic             swap_pending;

    logic             terminal_c;
    logic             boundary_c;
    logic             wr_c;
    logic             commit_c;
    logic [ROW_W-1:0] wr_row_c;
    logic [COLS-1:0]  wr_pix_c;
    logic             unused_bits;

    // Decode of divider terminal count, frame boundary and CPU write.
    always_comb begin
        terminal_c = (div_cnt == (SCAN_DIV - DIV_W'(1)));
        boundary_c = terminal_c && (row == ROW_W'(ROWS - 1));
        wr_c       = conf_wen && (conf_addr[15:0] == SCAN_ADDR);
        commit_c   = cpu_data_wdata[31];
        wr_row_c   = cpu_data_wdata[2:0];
        wr_pix_c   = cpu_data_wdata[15:8];
    end

    // Address and data bits that carry no meaning for this block.
    assign unused_bits = ^{conf_addr[31:16], cpu_data_wdata[30:16], cpu_data_wdata[7:3]};

    // Row-period divider: counts 0..SCAN_DIV-1 and wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (terminal_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Row index advances once per divider period and wraps 7 -> 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= '0;
        end else if (terminal_c) begin
            row <= row + ROW_W'(1);
        end
    end

    // Back buffer: one row per CPU write; row data is always stored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROWS; i++) begin
                back[i] <= '0;
            end
        end else if (wr_c) begin
            back[wr_row_c] <= wr_pix_c;
        end
    end

    // Front buffer: whole-image copy at a frame boundary when a commit is pending.
    // Nonblocking semantics make a coinciding write land after the copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROWS; i++) begin
                front[i] <= '0;
            end
        end else if (boundary_c && swap_pending) begin
            for (int i = 0; i < ROWS; i++) begin
                front[i] <= back[i];
            end
        end
    end

    // Commit flag: a new commit wins over the clear from a coinciding swap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            swap_pending <= 1'b0;
        end else if (wr_c && commit_c) begin
            swap_pending <= 1'b1;
        end else if (boundary_c) begin
            swap_pending <= 1'b0;
        end
    end

    // Registered pin drive: one-hot row, active-low columns, frame pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_dotr   <= 8'h00;
            led_dotc   <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            led_dotr   <= 8'h01 << row;
            led_dotc   <= ~front[row];
            frame_done <= boundary_c;
        end
    end

endmodule

// File: tb/tb_leddot_scan.sv
// Bench for leddot_scan with a short row period of 4 clocks.
module tb_leddot_scan;

    localparam logic [15:0] DIV  = 16'd4;
    localparam logic [15:0] ADDR = 16'hf004;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] conf_addr;
    logic        conf_wen;
    logic [31:0] cpu_data_wdata;
    logic [7:0]  led_dotr;
    logic [7:0]  led_dotc;
    logic        frame_done;

    always #5 clk = ~clk;

    leddot_scan #(.SCAN_DIV(DIV), .SCAN_ADDR(ADDR)) dut (
        .clk            (clk),
        .reset          (reset),
        .conf_addr      (conf_addr),
        .conf_wen       (conf_wen),
        .cpu_data_wdata (cpu_data_wdata),
        .led_dotr       (led_dotr),
        .led_dotc       (led_dotc),
        .frame_done     (frame_done)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] dotr;
        logic [7:0] dotc;
        logic       fd;
    } obs_t;

    obs_t sbq[$];

    typedef struct {
        logic        wen;
        logic [15:0] addr;
        logic [2:0]  row;
        logic [7:0]  pix;
        logic        commit;
        logic [7:0]  exp_dotc;
    } vec_t;

    vec_t vecs[8];

    // Reference state of the display pipeline.
    int         m_cnt;
    int         m_row;
    logic [7:0] m_back  [8];
    logic [7:0] m_front [8];
    logic       m_swap;

    task automatic model_reset();
        m_cnt  = 0;
        m_row  = 0;
        m_swap = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_back[i]  = 8'h00;
            m_front[i] = 8'h00;
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wdata(input logic [2:0] r, input logic [7:0] pix, input logic commit);
        return {commit, 15'b0, pix, 5'b0, r};
    endfunction

    // One clock: drive inputs, predict the post-edge outputs, then compare.
    task automatic tick(input logic wen, input logic [31:0] addr, input logic [31:0] data);
        obs_t e;
        bit   tc, fb, wr;
        conf_wen       = wen;
        conf_addr      = addr;
        cpu_data_wdata = data;
        tc = (m_cnt == int'(DIV) - 1);
        fb = tc && (m_row == 7);
        wr = wen && (addr[15:0] == ADDR);
        e.dotr = 8'h01 << m_row;
        e.dotc = ~m_front[m_row];
        e.fd   = fb;
        sbq.push_back(e);
        if (fb && m_swap) begin
            for (int i = 0; i < 8; i++) m_front[i] = m_back[i];
            m_swap = 1'b0;
        end
        if (wr) begin
            m_back[data[2:0]] = data[15:8];
            if (data[31]) m_swap = 1'b1;
        end
        m_cnt = tc ? 0 : m_cnt + 1;
        if (tc) m_row = (m_row + 1) % 8;
        @(posedge clk);
        @(negedge clk);
        conf_wen = 1'b0;
        e = sbq.pop_front();
        check8("sb_dotr", led_dotr, e.dotr);
        check8("sb_dotc", led_dotc, e.dotc);
        check8("sb_frame_done", {7'b0, frame_done}, {7'b0, e.fd});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 32'h0);
    endtask

    // Step until the given row is on the pins, then return its columns.
    task automatic capture_row(input int r, output logic [7:0] c);
        int n = 0;
        while (led_dotr !== (8'h01 << r) && n < 40) begin
            idle(1);
            n++;
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL row_wait: row %0d never shown, dotr %h", r, led_dotr);
        end
        c = led_dotc;
    endtask

    task automatic run_to_boundary();
        int n = 0;
        while (!(m_cnt == int'(DIV) - 1 && m_row == 7) && n < 40) begin
            idle(1);
            n++;
        end
    endtask

    task automatic check_reset_pins(input string tag);
        check8({tag, "_dotr"}, led_dotr, 8'h00);
        check8({tag, "_dotc"}, led_dotc, 8'hFF);
        check8({tag, "_fd"}, {7'b0, frame_done}, 8'h00);
    endtask

    initial begin
        logic [7:0] c;
        int         fd_count;

        vecs[0] = '{1'b1, 16'hf004, 3'd3, 8'hA5, 1'b0, 8'hFF};
        vecs[1] = '{1'b1, 16'hf004, 3'd3, 8'hA5, 1'b1, 8'h5A};
        vecs[2] = '{1'b1, 16'hf000, 3'd0, 8'hFF, 1'b1, 8'hFF};
        vecs[3] = '{1'b1, 16'hf004, 3'd5, 8'h3C, 1'b0, 8'hFF};
        vecs[4] = '{1'b1, 16'hf004, 3'd6, 8'h81, 1'b1, 8'h7E};
        vecs[5] = '{1'b1, 16'hf004, 3'd5, 8'h3C, 1'b1, 8'hC3};
        vecs[6] = '{1'b1, 16'hf004, 3'd3, 8'h00, 1'b1, 8'hFF};
        vecs[7] = '{1'b0, 16'hf004, 3'd1, 8'hFF, 1'b1, 8'hFF};

        reset          = 1'b1;
        conf_wen       = 1'b0;
        conf_addr      = 32'h0;
        cpu_data_wdata = 32'h0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_pins("reset");
        reset = 1'b0;

        // First edge after release shows row 0, blank.
        idle(1);
        check8("first_dotr", led_dotr, 8'h01);
        check8("first_dotc", led_dotc, 8'hFF);

        // Idle scan: two frame pulses in any 64-cycle window.
        fd_count = 0;
        for (int i = 0; i < 64; i++) begin
            idle(1);
            if (frame_done) fd_count++;
        end
        check8("fd_count", 8'(fd_count), 8'd2);

        // Table of single writes, each followed by settling and a row check.
        for (int v = 0; v < 8; v++) begin
            idle(10);
            tick(vecs[v].wen, {16'h0, vecs[v].addr},
                 wdata(vecs[v].row, vecs[v].pix, vecs[v].commit));
            idle(70);
            capture_row(int'(vecs[v].row), c);
            check8($sformatf("vec%0d_dotc", v), c, vecs[v].exp_dotc);
        end

        // Commit write exactly on the frame-boundary cycle.
        run_to_boundary();
        tick(1'b1, {16'h0, ADDR}, wdata(3'd0, 8'hFF, 1'b1));
        capture_row(0, c);
        check8("boundary_old_row0", c, 8'hFF);
        idle(8);
        capture_row(0, c);
        check8("boundary_new_row0", c, 8'h00);

        // Reset mid-frame after a committed write.
        idle(7);
        tick(1'b1, {16'h0, ADDR}, wdata(3'd2, 8'h0F, 1'b1));
        idle(40);
        capture_row(2, c);
        check8("pre_reset_row2", c, 8'hF0);
        idle(5);
        reset = 1'b1;
        #1;
        check_reset_pins("async_reset");
        sbq.delete();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_reset_pins("held_reset");
        reset = 1'b0;
        idle(1);
        check8("restart_dotr", led_dotr, 8'h01);
        check8("restart_dotc", led_dotc, 8'hFF);
        idle(40);
        capture_row(2, c);
        check8("post_reset_row2", c, 8'hFF);
        capture_row(0, c);
        check8("post_reset_row0", c, 8'hFF);
        idle(70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/leddot_scan.md
LEDDOT_SCAN -- requirements
Module: leddot_scan

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 16'd50000, giving clk cycles per displayed row (legal range 2..65535).
REQ-002 The module SHALL have parameter SCAN_ADDR, default 16'hf004, the low-16-bit write address decoded from conf_addr.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port conf_addr, input, 32 bits: CPU write address; only bits [15:0] are decoded.
REQ-006 The module SHALL have port conf_wen, input, 1 bit: CPU write strobe, one cycle per write.
REQ-007 The module SHALL have port cpu_data_wdata, input, 32 bits: write data; [2:0] row index, [15:8] row pixels (1 = lit), [31] commit.
REQ-008 The module SHALL have port led_dotr, output, 8 bits: one-hot row drive, active-high.
REQ-009 The module SHALL have port led_dotc, output, 8 bits: column drive, active-low (0 = pixel lit).
REQ-010 The module SHALL have port frame_done, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-011 The module SHALL hold two 8x8 buffers: back (CPU-written) and front (displayed).
REQ-012 A write SHALL occur when conf_wen=1 and conf_addr[15:0]=SCAN_ADDR: back[wdata[2:0]] <= wdata[15:8], taking effect on that edge.
REQ-013 A write with wdata[31]=1 SHALL also set swap_pending; the row data of that write SHALL always be stored.
REQ-014 Writes to any other address, or with conf_wen=0, SHALL change no state.
REQ-015 A divider SHALL count 0..SCAN_DIV-1 and wrap; its terminal count (SCAN_DIV-1) SHALL advance row index 0->1->...->7->0.
REQ-016 A frame boundary SHALL be the cycle with terminal count and row index 7.
REQ-017 At a frame boundary with swap_pending=1, front SHALL be loaded with all 8 rows of back and swap_pending cleared on that edge.
REQ-018 At a frame boundary with swap_pending=0, front SHALL remain unchanged.
REQ-019 frame_done SHALL be 1 for exactly the one cycle after each frame-boundary edge, independent of swap_pending.
REQ-020 If a write coincides with a frame boundary, the copy SHALL use back as it was before that write.
REQ-021 If the coinciding write has commit=1, swap_pending SHALL end at 1, so that write is shown at the next boundary.
REQ-022 led_dotr SHALL be registered as 8'b1 << row and led_dotc SHALL be registered as ~front[row], giving one cycle latency from row/front change to pins.
REQ-023 led_dotr SHALL never have more than one bit set.

Reset
REQ-024 While reset=1, the module SHALL immediately hold: divider 0, row 0, back and front all 0, swap_pending 0, led_dotr 8'h00, led_dotc 8'hFF, frame_done 0.
REQ-025 Reset asserted mid-frame or mid-write SHALL discard all pending state with no partial swap.
REQ-026 On the first rising edge after reset deasserts, led_dotr SHALL be 8'h01 and led_dotc 8'hFF.

Verification (SCAN_DIV=4)
REQ-027 Scenario: release reset, no writes -> led_dotr steps 01,02,...,80 every 4 cycles; led_dotc stays FF; frame_done pulses every 32 cycles.
REQ-028 Scenario: write row 3 = 8'hA5 with commit=0 -> the display is unchanged across 3 frames (led_dotc FF during row 3).
REQ-029 Scenario: write row 3 = 8'hA5 with commit=1 mid-frame -> from the next frame, led_dotc=8'h5A while led_dotr=8'h08, and FF on all other rows.
REQ-030 Scenario: commit write of row 0 = 8'hFF on the exact frame-boundary cycle -> the next frame shows the old row 0; the following frame shows led_dotc=8'h00 on row 0.
REQ-031 Scenario: write to address 16'hf000 with row 0 = 8'hFF and commit=1 -> no change ever, and swap_pending stays 0.
REQ-032 Scenario: reset asserted mid-frame after a committed write -> outputs go to 00/FF asynchronously; after release the display is blank and scanning restarts at row 0.
